// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM encoding, data width and default parameters for uart_tx_arbiter
package uart_arb_pkg;
  localparam int UART_DATA_W = 9;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_BUSY_TIMEOUT = 4;
  localparam int TIMEOUT_W = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND,
    WAIT_BUSY = ST_WAIT_BUSY,
    WAIT_DONE = ST_WAIT_DONE
  } state_e;
  function automatic int next_index(input int idx, input int n);
    return (idx == n - 1) ? 0 : idx + 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first active request at or above ptr, wrapping at N-1
module rr_arbiter #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         valid
);
  logic [W-1:0] j;
  always_comb begin
    idx = '0;
    valid = 1'b0;
    j = '0;
    for (int i = 0; i < N; i++) begin
      j = W'((int'(ptr) + i) % N);
      if (!valid && req[j]) begin
        idx = j;
        valid = 1'b1;
      end
    end
    grant = valid ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one 9N1 UART transmitter among NUM_REQ requesters
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
  localparam int GW = $clog2(NUM_REQ)
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [NUM_REQ-1:0][UART_DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]                  ack,
  input  logic                                uart_ready,
  output logic                                uart_send,
  output logic [UART_DATA_W-1:0]              uart_data,
  output logic                                busy,
  output logic [GW-1:0]                       grant_id,
  output logic                                tx_error
);
  state_e state, state_nx;
  logic [GW-1:0] ptr, win_idx;
  logic [NUM_REQ-1:0] win_onehot;
  logic [UART_DATA_W-1:0] win_word;
  logic win_valid, grant_now, timeout;
  logic [TIMEOUT_W-1:0] cnt;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req  (req),
    .ptr  (ptr),
    .grant(win_onehot),
    .idx  (win_idx),
    .valid(win_valid)
  );

  always_comb begin
    win_word = '0;
    for (int i = 0; i < NUM_REQ; i++) win_word |= win_onehot[i] ? req_data[i] : '0;
  end

  // uart_ready gates the grant so nothing is handed over while the transmitter is still busy
  always_comb begin
    grant_now = (state == IDLE) && uart_ready && win_valid;
    timeout = (state == WAIT_BUSY) && uart_ready && (cnt == TIMEOUT_W'(BUSY_TIMEOUT - 1));
    state_nx = grant_now ? SEND
      : (state == SEND) ? WAIT_BUSY
      : (state == WAIT_BUSY) ? (!uart_ready ? WAIT_DONE : (timeout ? IDLE : WAIT_BUSY))
      : (state == WAIT_DONE) ? (uart_ready ? IDLE : WAIT_DONE)
      : IDLE;
  end

  always_comb ack = (state == SEND) ? NUM_REQ'(1) << grant_id : '0;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ptr <= '0;
      grant_id <= '0;
      uart_data <= '0;
      cnt <= '0;
      uart_send <= 1'b0;
      busy <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      state <= state_nx;
      busy <= state_nx != IDLE;
      uart_send <= grant_now;
      tx_error <= timeout;
      cnt <= (state == WAIT_BUSY && uart_ready) ? cnt + 1'b1 : '0;
      if (grant_now) begin
        grant_id <= win_idx;
        ptr <= GW'(next_index(int'(win_idx), NUM_REQ));
        uart_data <= win_word;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios for uart_tx_arbiter with hand-computed expectations
module tb_uart_tx_arbiter;
  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic [3:0] req = '0;
  logic [3:0][8:0] req_data = '0;
  logic uart_ready = 1'b1;
  logic [3:0] ack;
  logic uart_send;
  logic [8:0] uart_data;
  logic busy;
  logic [1:0] grant_id;
  logic tx_error;
  logic [2:0] req3 = '0;
  logic [2:0][8:0] req_data3 = '0;
  logic uart_ready3 = 1'b1;
  logic [2:0] ack3;
  logic uart_send3;
  logic [8:0] uart_data3;
  logic busy3;
  logic [1:0] grant_id3;
  logic tx_error3;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  uart_tx_arbiter #(.NUM_REQ(4), .BUSY_TIMEOUT(4)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_data(req_data), .ack(ack),
    .uart_ready(uart_ready), .uart_send(uart_send), .uart_data(uart_data),
    .busy(busy), .grant_id(grant_id), .tx_error(tx_error)
  );

  uart_tx_arbiter #(.NUM_REQ(3), .BUSY_TIMEOUT(4)) dut3 (
    .clock(clock), .reset_n(reset_n), .req(req3), .req_data(req_data3), .ack(ack3),
    .uart_ready(uart_ready3), .uart_send(uart_send3), .uart_data(uart_data3),
    .busy(busy3), .grant_id(grant_id3), .tx_error(tx_error3)
  );

  always @(negedge clock) if (reset_n) begin
    n_cmp++;
    if ($countones(ack) > 1 || (ack != 4'b0 && uart_send !== 1'b1)) begin
      n_bad++;
      $display("FAIL ack_exclusive: ack=%b send=%b want at most one ack and only with send", ack, uart_send);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    req3 = '0;
    uart_ready = 1'b1;
    uart_ready3 = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic wait_send(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16 && !ok; i++) begin
      tick();
      ok = uart_send;
    end
  endtask

  task automatic test_reset();
    #2;
    reset_n = 1'b0;
    req = 4'hF;
    uart_ready = 1'b1;
    tick();
    n_cmp++; if (uart_send !== 1'b0) begin n_bad++; $display("FAIL reset_send: got %b want 0", uart_send); end
    n_cmp++; if (ack !== 4'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0000", ack); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL reset_grant_id: got %0d want 0", grant_id); end
    n_cmp++; if (uart_data !== 9'h0) begin n_bad++; $display("FAIL reset_data: got %h want 000", uart_data); end
    n_cmp++; if (tx_error !== 1'b0) begin n_bad++; $display("FAIL reset_tx_error: got %b want 0", tx_error); end
  endtask

  task automatic test_single();
    do_reset();
    req_data[2] = 9'h1A5;
    req = 4'b0100;
    uart_ready = 1'b1;
    #1;
    n_cmp++; if (uart_send !== 1'b0) begin n_bad++; $display("FAIL single_early_send: got %b want 0", uart_send); end
    tick();
    n_cmp++; if (uart_send !== 1'b1) begin n_bad++; $display("FAIL single_send: got %b want 1", uart_send); end
    n_cmp++; if (ack !== 4'b0100) begin n_bad++; $display("FAIL single_ack: got %b want 0100", ack); end
    n_cmp++; if (uart_data !== 9'h1A5) begin n_bad++; $display("FAIL single_data: got %h want 1a5", uart_data); end
    n_cmp++; if (grant_id !== 2'd2) begin n_bad++; $display("FAIL single_grant_id: got %0d want 2", grant_id); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %b want 1", busy); end
    req = 4'b0000;
    uart_ready = 1'b0;
    tick();
    n_cmp++; if (uart_send !== 1'b0 || ack !== 4'b0) begin n_bad++; $display("FAIL single_pulse_width: send=%b ack=%b want 0 0000", uart_send, ack); end
    tick();
    tick();
    uart_ready = 1'b1;
    tick();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL single_done_busy: got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [8:0] exp_d [4] = '{9'h03C, 9'h155, 9'h0AB, 9'h1F0};
    bit ok;
    int extra;
    do_reset();
    req_data = {9'h1F0, 9'h0AB, 9'h155, 9'h03C};
    req = 4'hF;
    uart_ready = 1'b1;
    for (int w = 0; w < 5; w++) begin
      wait_send(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rr_send word %0d: got no send want send", w); end
      n_cmp++; if (grant_id !== 2'(exp_order[w])) begin n_bad++; $display("FAIL rr_grant word %0d: got %0d want %0d", w, grant_id, exp_order[w]); end
      n_cmp++; if (ack !== 4'(1 << exp_order[w])) begin n_bad++; $display("FAIL rr_ack word %0d: got %b want %b", w, ack, 4'(1 << exp_order[w])); end
      n_cmp++; if (uart_data !== exp_d[exp_order[w]]) begin n_bad++; $display("FAIL rr_data word %0d: got %h want %h", w, uart_data, exp_d[exp_order[w]]); end
      uart_ready = 1'b0;
      extra = 0;
      for (int c = 0; c < 12; c++) begin
        tick();
        if (ack !== 4'b0 || uart_send !== 1'b0) extra++;
      end
      n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL rr_overlap word %0d: got %0d extra sends want 0", w, extra); end
      uart_ready = 1'b1;
    end
    req = 4'b0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    do_reset();
    req_data = {9'h004, 9'h003, 9'h002, 9'h001};
    req = 4'b1010;
    uart_ready = 1'b1;
    tick();
    n_cmp++; if (grant_id !== 2'd1 || ack !== 4'b0010) begin n_bad++; $display("FAIL b2b_first: grant=%0d ack=%b want 1 0010", grant_id, ack); end
    req = 4'b1000;
    uart_ready = 1'b0;
    tick();
    req = 4'b1010;
    tick();
    uart_ready = 1'b1;
    wait_send(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_second_send: got no send want send"); end
    n_cmp++; if (grant_id !== 2'd3) begin n_bad++; $display("FAIL b2b_second_grant: got %0d want 3", grant_id); end
    n_cmp++; if (uart_data !== 9'h004) begin n_bad++; $display("FAIL b2b_second_data: got %h want 004", uart_data); end
    req = 4'b0010;
    uart_ready = 1'b0;
    tick();
    tick();
    uart_ready = 1'b1;
    wait_send(ok);
    n_cmp++; if (!ok || grant_id !== 2'd1 || ack !== 4'b0010) begin n_bad++; $display("FAIL b2b_third: send=%b grant=%0d ack=%b want 1 1 0010", ok, grant_id, ack); end
    req = 4'b0;
  endtask

  task automatic test_timeout();
    int early;
    do_reset();
    req_data[0] = 9'h0F0;
    req = 4'b0001;
    uart_ready = 1'b1;
    tick();
    n_cmp++; if (uart_send !== 1'b1) begin n_bad++; $display("FAIL to_send: got %b want 1", uart_send); end
    req = 4'b0;
    early = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (tx_error !== 1'b0 || busy !== 1'b1) early++;
    end
    n_cmp++; if (early != 0) begin n_bad++; $display("FAIL to_early: got %0d bad cycles want 0", early); end
    tick();
    n_cmp++; if (tx_error !== 1'b1) begin n_bad++; $display("FAIL to_pulse: got %b want 1", tx_error); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL to_idle: got busy %b want 0", busy); end
    tick();
    n_cmp++; if (tx_error !== 1'b0) begin n_bad++; $display("FAIL to_one_cycle: got %b want 0", tx_error); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_data = {9'h0, 9'h0, 9'h0EE, 9'h111};
    req = 4'b0010;
    uart_ready = 1'b1;
    tick();
    uart_ready = 1'b0;
    tick();
    tick();
    req = 4'b0111;
    n_cmp++; if (busy !== 1'b1 || grant_id !== 2'd1) begin n_bad++; $display("FAIL rm_pre: busy=%b grant=%0d want 1 1", busy, grant_id); end
    reset_n = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_cmp++; if (grant_id !== 2'd0) begin n_bad++; $display("FAIL rm_grant_id: got %0d want 0", grant_id); end
    n_cmp++; if (uart_data !== 9'h0) begin n_bad++; $display("FAIL rm_data: got %h want 000", uart_data); end
    n_cmp++; if (uart_send !== 1'b0 || ack !== 4'b0) begin n_bad++; $display("FAIL rm_send: send=%b ack=%b want 0 0000", uart_send, ack); end
    uart_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    n_cmp++; if (uart_send !== 1'b1) begin n_bad++; $display("FAIL rm_fresh_send: got %b want 1", uart_send); end
    n_cmp++; if (grant_id !== 2'd0 || ack !== 4'b0001) begin n_bad++; $display("FAIL rm_fresh_grant: grant=%0d ack=%b want 0 0001", grant_id, ack); end
    n_cmp++; if (uart_data !== 9'h111) begin n_bad++; $display("FAIL rm_fresh_data: got %h want 111", uart_data); end
    req = 4'b0;
  endtask

  task automatic test_ready_low();
    int seen;
    reset_n = 1'b0;
    uart_ready = 1'b0;
    req = 4'b0001;
    req_data[0] = 9'h07E;
    #1;
    reset_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (uart_send !== 1'b0 || busy !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL rl_blocked: got %0d active cycles want 0", seen); end
    uart_ready = 1'b1;
    tick();
    n_cmp++; if (uart_send !== 1'b1 || uart_data !== 9'h07E) begin n_bad++; $display("FAIL rl_send: send=%b data=%h want 1 07e", uart_send, uart_data); end
    req = 4'b0;
  endtask

  task automatic test_withdraw();
    int seen;
    do_reset();
    uart_ready = 1'b0;
    req = 4'b0100;
    tick();
    tick();
    req = 4'b0;
    uart_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (uart_send !== 1'b0 || ack !== 4'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL wd_no_send: got %0d sends want 0", seen); end
  endtask

  task automatic test_npot();
    int exp_order [5] = '{0, 1, 2, 0, 1};
    logic [8:0] exp_d [3] = '{9'h011, 9'h022, 9'h033};
    bit ok;
    do_reset();
    req_data3 = {9'h033, 9'h022, 9'h011};
    req3 = 3'b111;
    uart_ready3 = 1'b1;
    for (int w = 0; w < 5; w++) begin
      ok = 1'b0;
      for (int i = 0; i < 16 && !ok; i++) begin
        tick();
        ok = uart_send3;
      end
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL np_send word %0d: got no send want send", w); end
      n_cmp++; if (grant_id3 !== 2'(exp_order[w]) || ack3 !== 3'(1 << exp_order[w])) begin n_bad++; $display("FAIL np_grant word %0d: grant=%0d ack=%b want %0d", w, grant_id3, ack3, exp_order[w]); end
      n_cmp++; if (uart_data3 !== exp_d[exp_order[w]]) begin n_bad++; $display("FAIL np_data word %0d: got %h want %h", w, uart_data3, exp_d[exp_order[w]]); end
      uart_ready3 = 1'b0;
      tick();
      uart_ready3 = 1'b1;
    end
    req3 = 3'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    test_ready_low();
    test_withdraw();
    test_npot();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000ns");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one 9N1 UART transmitter; legal range 2..8.
REQ-002 Parameter BUSY_TIMEOUT, default 4: cycles to wait for uart_ready to fall after a send pulse; legal range 2..15.
REQ-003 clock  input  1  single clock; all logic on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  NUM_REQ  per-requester transmit request; held high until the matching ack.
REQ-006 req_data  input  NUM_REQ x 9  per-requester 9-bit word; stable while the matching req is high.
REQ-007 ack  output  NUM_REQ  one-cycle pulse; the word of requester k has been handed to the UART.
REQ-008 uart_ready  input  1  ready from the transmitter; high when idle.
REQ-009 uart_send  output  1  one-cycle send pulse to the transmitter.
REQ-010 uart_data  output  9  word to the transmitter; valid while uart_send is high.
REQ-011 busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 grant_id  output  clog2(NUM_REQ)  index of the current or most recent granted requester.
REQ-013 tx_error  output  1  one-cycle pulse when BUSY_TIMEOUT expires.

Function
REQ-014 FSM states: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE -> SEND when any req bit is high and uart_ready=1; grant_id and the held word latch the round-robin winner on that edge.
REQ-016 Round-robin: search starts at pointer ptr and goes upward with wrap; winner = first high req at or after ptr.
REQ-017 ptr = winner+1 modulo NUM_REQ, updated on the grant edge.
REQ-018 SEND lasts exactly one cycle: uart_send=1, uart_data=latched word, ack[grant_id]=1; next state is WAIT_BUSY.
REQ-019 Latency: req high with uart_ready high in cycle N gives uart_send and ack in cycle N+1.
REQ-020 WAIT_BUSY -> WAIT_DONE when uart_ready=0.
REQ-021 WAIT_BUSY -> IDLE when uart_ready stays 1 for BUSY_TIMEOUT consecutive cycles; tx_error pulses on that transition.
REQ-022 WAIT_DONE -> IDLE when uart_ready=1; the earliest next grant is in that same IDLE cycle.
REQ-023 While in IDLE with uart_ready=0, no grant is made; req is ignored until uart_ready rises.
REQ-024 A req dropped before the grant edge produces no send and no ack; a req dropped after the grant does not cancel the send of the latched word.
REQ-025 New or withdrawn req bits during SEND, WAIT_BUSY and WAIT_DONE do not affect the transfer in flight.
REQ-026 At most one ack bit is high in any cycle; ack only occurs coincident with uart_send.
REQ-027 NUM_REQ not a power of two: the pointer wraps at NUM_REQ-1, never at the power-of-two boundary.

Reset
REQ-028 reset_n low forces, asynchronously: state=IDLE, ptr=0, grant_id=0, held word=0, timeout counter=0, uart_send=0, uart_data=0, ack=0, busy=0, tx_error=0.
REQ-029 Reset asserted mid-transfer abandons it; no ack or send is issued for the abandoned word after release.
REQ-030 The first grant after release starts the search at requester 0.

Structure
REQ-031 Package uart_arb_pkg holds the FSM state enum, the constant UART_DATA_W=9, and the default parameter constants.
REQ-032 One sub-module rr_arbiter (combinational: req vector + ptr -> one-hot winner, index, valid), instantiated once.
REQ-033 All outputs are registered except ack, which is decoded from state==SEND and grant_id.

Verification
REQ-034 Single request: req=4'b0100, data[2]=9'h1A5, uart_ready=1 -> uart_send and ack=4'b0100 one cycle later, uart_data=9'h1A5, grant_id=2.
REQ-035 All four req held, ready model drops for 12 cycles per word -> grants in order 0,1,2,3,0; exactly one ack per word; no overlap.
REQ-036 Back-to-back: req[1] re-asserted immediately after its ack with req[3] pending -> requester 3 is granted before requester 1 again.
REQ-037 Stuck ready: uart_ready held 1 after send, BUSY_TIMEOUT=4 -> tx_error pulses 4 cycles after WAIT_BUSY entry; FSM returns to IDLE.
REQ-038 Reset during WAIT_DONE with req[0] high -> all outputs 0 immediately; after release, requester 0 is granted as a fresh transfer.
REQ-039 uart_ready low at reset release with req=4'b0001 -> no send until uart_ready rises, then send on the next cycle.
